// File: rtl/afe_spi_frame_rx.sv
// Receive-side decoder for the AFE serial control lines: oversamples SPI clk/sdi/le
// in sysClk, shifts SDI on clock rises and hands each LE-latched frame out over valid/ready.
module afe_spi_frame_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH+2),
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sysClk,
  input  logic                  sysReset_n,
  input  logic                  spiClk,
  input  logic                  spiSdi,
  input  logic                  spiLe,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic [CNT_WIDTH-1:0]  rxBitCount,
  output logic                  rxValid,
  input  logic                  rxReady,
  input  logic                  clearFlags,
  output logic                  overrun,
  output logic                  frameError,
  output logic                  busy
);

  localparam int LN_CLK = 0;
  localparam int LN_SDI = 1;
  localparam int LN_LE  = 2;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic {ST_ARM, ST_SHIFT} state_t;

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] dly_q;
  logic       clk_rise_q, le_rise_q;
  logic       sdi, le_hi;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [CNT_WIDTH-1:0]    rx_cnt_q, rx_cnt_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;

  // Edge pulses are registered so they line up with dly_q, which then carries
  // the SDI bit and LE level belonging to the same sample.
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q      <= '0;
      clk_rise_q <= 1'b0;
      le_rise_q  <= 1'b0;
    end else begin
      sync_q[0] <= {spiLe, spiSdi, spiClk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q      <= sync_q[SYNC_STAGES-1];
      clk_rise_q <= sync_q[SYNC_STAGES-1][LN_CLK] & ~dly_q[LN_CLK];
      le_rise_q  <= sync_q[SYNC_STAGES-1][LN_LE] & ~dly_q[LN_LE];
    end
  end

  assign sdi   = dly_q[LN_SDI];
  assign le_hi = dly_q[LN_LE];

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q     <= ST_ARM;
      sr_q        <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_cnt_q    <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    logic deliver, err_set, ovr_set, accept;
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_cnt_d   = rx_cnt_q;
    rx_valid_d = rx_valid_q;
    deliver    = 1'b0;
    err_set    = 1'b0;
    ovr_set    = 1'b0;
    accept     = rx_valid_q & rxReady;

    case (state_q)
      ST_ARM: begin
        // The frame in flight at reset is unknown, so only its closing LE is used.
        if (le_rise_q) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (le_rise_q) begin
          if (cnt_q == '0 || cnt_q > FULL_CNT) err_set = 1'b1;
          else                                 deliver = 1'b1;
          sr_d  = '0;
          cnt_d = '0;
        end else if (clk_rise_q && !le_hi) begin
          sr_d = {sr_q[DATA_WIDTH-2:0], sdi};
          if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (deliver && (!rx_valid_q || accept)) begin
      rx_data_d  = sr_q;
      rx_cnt_d   = cnt_q;
      rx_valid_d = 1'b1;
    end else begin
      if (deliver) ovr_set = 1'b1;
      if (accept)  rx_valid_d = 1'b0;
    end

    overrun_d   = ovr_set | (overrun_q & ~clearFlags);
    frame_err_d = err_set | (frame_err_q & ~clearFlags);
  end

  assign rxData     = rx_data_q;
  assign rxBitCount = rx_cnt_q;
  assign rxValid    = rx_valid_q;
  assign overrun    = overrun_q;
  assign frameError = frame_err_q;
  assign busy       = (state_q == ST_SHIFT) && (cnt_q != '0);

endmodule

// File: tb/tb_afe_spi_frame_rx.sv
// Self-checking bench for afe_spi_frame_rx: drives SPI frames bit by bit and compares
// delivered words against a frame-level reference model.
module tb_afe_spi_frame_rx;
  localparam int DW = 24;
  localparam int CW = $clog2(DW + 2);

  logic          sysClk = 1'b0;
  logic          sysReset_n = 1'b0;
  logic          spiClk = 1'b0, spiSdi = 1'b0, spiLe = 1'b0;
  logic [DW-1:0] rxData;
  logic [CW-1:0] rxBitCount;
  logic          rxValid, rxReady = 1'b1, clearFlags = 1'b0;
  logic          overrun, frameError, busy;

  afe_spi_frame_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .spiClk(spiClk), .spiSdi(spiSdi),
    .spiLe(spiLe), .rxData(rxData), .rxBitCount(rxBitCount), .rxValid(rxValid),
    .rxReady(rxReady), .clearFlags(clearFlags), .overrun(overrun),
    .frameError(frameError), .busy(busy)
  );

  always #5 sysClk = ~sysClk;

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed accepted words, captured mid-cycle.
  logic [DW-1:0] obs_data[$];
  logic [CW-1:0] obs_cnt[$];
  int valid_rise_cyc = -1;
  int valid_hi = 0;
  bit valid_prev = 0;

  initial forever begin
    @(negedge sysClk);
    if (rxValid === 1'b1) valid_hi++;
    if (rxValid === 1'b1 && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = (rxValid === 1'b1);
    if (rxValid === 1'b1 && rxReady === 1'b1) begin
      obs_data.push_back(rxData);
      obs_cnt.push_back(rxBitCount);
    end
  end

  // Reference model: frame-level rules only.
  bit            armed = 0;
  bit            exp_ferr = 0;
  logic [DW-1:0] exp_data[$];
  logic [CW-1:0] exp_cnt[$];
  int            le_cap = 0;

  task automatic model_frame(input logic [31:0] v, input int n);
    $display("frame bits=%0d data=%0h armed=%0d", n, v, armed);
    if (!armed) armed = 1;
    else if (n == 0 || n > DW) exp_ferr = 1;
    else begin
      exp_data.push_back(DW'(v % (32'd1 << n)));
      exp_cnt.push_back(CW'(n));
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spiSdi = v[i];
      spiClk = 1'b0;
      ticks(4);
      spiClk = 1'b1;
      ticks(4);
    end
  endtask

  // LE pulse; optionally raises rxReady for exactly the cycle in which the frame is delivered.
  task automatic pulse_le(input bit ready_pulse);
    spiClk = 1'b0;
    ticks(4);
    spiLe  = 1'b1;
    le_cap = cyc + 1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (ready_pulse && t == 3) rxReady = 1'b1;
      if (ready_pulse && t == 4) rxReady = 1'b0;
      if (t == 4) spiLe = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    send_bits(v, n);
    pulse_le(1'b0);
    model_frame(v, n);
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_cnt.delete(); exp_data.delete(); exp_cnt.delete();
  endtask

  task automatic pulse_clear();
    clearFlags = 1'b1; tick(); clearFlags = 1'b0; tick();
  endtask

  task automatic test_reset();
    sysReset_n = 1'b0;
    ticks(3);
    checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rxValid); end
    checks++; if (rxData !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rxData); end
    checks++; if (rxBitCount !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", rxBitCount); end
    checks++; if ({overrun, frameError, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {overrun, frameError, busy});
    end
    sysReset_n = 1'b1;
    armed = 0; exp_ferr = 0;
    ticks(2);
  endtask

  task automatic test_first_frame();
    int n;
    rxReady = 1'b1;
    clear_obs();
    n = $urandom_range(1, DW);
    send_frame($urandom, n);
    ticks(4);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL first_frame_dropped got %0d words exp 0", obs_data.size()); end
    valid_hi = 0; valid_rise_cyc = -1;
    send_bits(32'hA5C3F1, 24);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame got %b exp 1", busy); end
    pulse_le(1'b0);
    model_frame(32'hA5C3F1, 24);
    ticks(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_le got %b exp 0", busy); end
    checks++; if (valid_rise_cyc - le_cap != 3) begin
      errors++; $display("FAIL latency got %0d exp 3", valid_rise_cyc - le_cap);
    end
    checks++; if (valid_hi != 1) begin errors++; $display("FAIL valid_width got %0d exp 1", valid_hi); end
    checks++; if (obs_data.size() != 1 || exp_data.size() != 1) begin
      errors++; $display("FAIL second_frame_count got %0d exp 1", obs_data.size());
    end else begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL a5c3f1_data got %h exp %h", obs_data[0], exp_data[0]); end
      checks++; if (obs_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL a5c3f1_cnt got %0d exp %0d", obs_cnt[0], exp_cnt[0]); end
    end
    clear_obs();
  endtask

  task automatic test_short_frames();
    logic [31:0] v;
    int n;
    rxReady = 1'b1;
    for (int f = 0; f < 7; f++) begin
      clear_obs();
      if (f == 0) begin v = 32'h1234; n = 16; end
      else begin v = $urandom; n = $urandom_range(1, DW); end
      send_frame(v, n);
      ticks(4);
      checks++; if (obs_data.size() != exp_data.size() || obs_data.size() != 1) begin
        errors++; $display("FAIL frame%0d_count got %0d exp %0d", f, obs_data.size(), exp_data.size());
      end else begin
        checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL frame%0d_data got %h exp %h", f, obs_data[0], exp_data[0]); end
        checks++; if (obs_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL frame%0d_cnt got %0d exp %0d", f, obs_cnt[0], exp_cnt[0]); end
      end
      checks++; if (frameError !== exp_ferr) begin errors++; $display("FAIL frame%0d_ferr got %b exp %b", f, frameError, exp_ferr); end
    end
    clear_obs();
  endtask

  task automatic test_errors();
    rxReady = 1'b1;
    clear_obs();
    send_frame($urandom & 32'h1FF_FFFF, 25);
    ticks(4);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL oversize_delivered got %0d exp 0", obs_data.size()); end
    checks++; if (frameError !== exp_ferr) begin errors++; $display("FAIL oversize_ferr got %b exp %b", frameError, exp_ferr); end
    pulse_clear(); exp_ferr = 0;
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL clear_ferr got %b exp 0", frameError); end
    pulse_le(1'b0);
    model_frame(32'h0, 0);
    ticks(4);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL empty_delivered got %0d exp 0", obs_data.size()); end
    checks++; if (frameError !== exp_ferr) begin errors++; $display("FAIL empty_ferr got %b exp %b", frameError, exp_ferr); end
    pulse_clear(); exp_ferr = 0;
    clear_obs();
  endtask

  task automatic test_overrun();
    clear_obs();
    rxReady = 1'b0;
    send_bits(32'h1, 24); pulse_le(1'b0);
    send_bits(32'h2, 24); pulse_le(1'b0);
    ticks(4);
    checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rxValid); end
    checks++; if (rxData !== 24'h000001) begin errors++; $display("FAIL ovr_hold_data got %h exp 000001", rxData); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    rxReady = 1'b1; tick(); rxReady = 1'b0;
    checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL ovr_accept_drop got %b exp 0", rxValid); end
    pulse_clear();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    clear_obs();
  endtask

  task automatic test_back_to_back();
    clear_obs();
    rxReady = 1'b0;
    send_bits(32'h1, 24); pulse_le(1'b0);
    send_bits(32'h2, 24); pulse_le(1'b1);
    ticks(2);
    checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", rxValid); end
    checks++; if (rxData !== 24'h000002) begin errors++; $display("FAIL b2b_data got %h exp 000002", rxData); end
    checks++; if (rxBitCount !== CW'(24)) begin errors++; $display("FAIL b2b_cnt got %0d exp 24", rxBitCount); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    checks++; if (obs_data.size() != 1 || obs_data[0] !== 24'h000001) begin
      errors++; $display("FAIL b2b_first_accept got %0d words exp one 000001", obs_data.size());
    end
    rxReady = 1'b1;
    ticks(2);
    clear_obs();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    rxReady = 1'b1;
    clear_obs();
    v = $urandom & 32'hFF_FFFF;
    send_bits(v >> 14, 10);
    sysReset_n = 1'b0; ticks(2); sysReset_n = 1'b1;
    armed = 0; exp_ferr = 0;
    send_bits(v, 14);
    pulse_le(1'b0);
    model_frame(v, 24);
    ticks(4);
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL rst_mid_delivered got %0d exp 0", obs_data.size()); end
    checks++; if ({overrun, frameError} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got %b exp 00", {overrun, frameError}); end
    send_frame(32'hFF_FFFF, 24);
    ticks(4);
    checks++; if (obs_data.size() != 1 || exp_data.size() != 1) begin
      errors++; $display("FAIL rst_next_count got %0d exp 1", obs_data.size());
    end else begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL rst_next_data got %h exp %h", obs_data[0], exp_data[0]); end
      checks++; if (obs_cnt[0] !== exp_cnt[0]) begin errors++; $display("FAIL rst_next_cnt got %0d exp %0d", obs_cnt[0], exp_cnt[0]); end
    end
    clear_obs();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_short_frames();
    test_errors();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
